thin_sequencer: RTL and testbench

Pass scheduler for the iterative thinning stage. It launches the thinner once per pass and ping-pongs the source/destination frame buffers between passes. It counts the set pixels written in each pass and stops when the image converges or a pass limit is reached. It sits between the top-level image-pipeline FSM and the thinner/BRAM pair, and owns the buffer-select muxes.

---
 rtl/thin_sequencer_if.sv | 22 ++
 rtl/thin_sequencer.sv | 136 +++++++++++++
 tb/tb_thin_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thin_sequencer_if.sv
// Thinner-side handshake between the pass sequencer and the thinner core.
// The sequencer is the master: it launches passes and consumes pixel writes.
interface thin_sequencer_if;
    logic thinner_start;
    logic thinner_done;
    logic pix_we;
    logic pix_data;

    modport master (
        output thinner_start,
        input  thinner_done,
        input  pix_we,
        input  pix_data
    );

    modport slave (
        input  thinner_start,
        output thinner_done,
        output pix_we,
        output pix_data
    );
endinterface

// File: rtl/thin_sequencer.sv
// Pass scheduler for iterative thinning: launches passes, ping-pongs buffers,
// counts set pixels per pass and stops on convergence, pass limit or watchdog.
module thin_sequencer #(
    parameter int MAX_PASSES = 16,
    parameter int TIMEOUT    = 2500000,
    parameter int PIX_W      = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             converged,
    output logic [7:0]       pass_count,
    output logic [PIX_W-1:0] last_pixels,
    output logic             buf_sel,
    thin_sequencer_if.master th
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        EVAL,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PIX_W-1:0] pix_cnt;
    logic [PIX_W-1:0] prev_pix;
    logic [WD_W-1:0]  wd;
    logic             wd_err;
    logic             same;
    logic             limit;
    logic             expire;

    assign same   = (pix_cnt == prev_pix);
    assign limit  = (pass_count == 8'(MAX_PASSES - 1));
    assign expire = (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = LAUNCH;
            end
            LAUNCH: begin
                state_nx = abort ? FINISH : WAIT;
            end
            WAIT: begin
                if (abort)             state_nx = FINISH;
                else if (th.thinner_done) state_nx = EVAL;
                else if (expire)       state_nx = FINISH;
            end
            EVAL: begin
                if (abort || same || limit) state_nx = FINISH;
                else                        state_nx = LAUNCH;
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            converged        <= 1'b0;
            pass_count       <= '0;
            last_pixels      <= '0;
            buf_sel          <= 1'b0;
            th.thinner_start <= 1'b0;
            pix_cnt          <= '0;
            prev_pix         <= '1;
            wd               <= '0;
            wd_err           <= 1'b0;
        end else begin
            th.thinner_start <= (state == LAUNCH) && !abort;
            busy             <= (state_nx != IDLE);
            done             <= (state == FINISH) && !wd_err;
            error            <= (state == FINISH) && wd_err;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pass_count <= '0;
                        pix_cnt    <= '0;
                        wd         <= '0;
                        prev_pix   <= '1;
                        buf_sel    <= 1'b0;
                        converged  <= 1'b0;
                        wd_err     <= 1'b0;
                    end
                end
                LAUNCH: begin
                    pix_cnt <= '0;
                    wd      <= '0;
                end
                WAIT: begin
                    if (th.pix_we && th.pix_data && pix_cnt != '1)
                        pix_cnt <= pix_cnt + PIX_W'(1);
                    wd <= wd + WD_W'(1);
                    // expiry only counts as an error if nothing else ends the pass
                    if (!abort && !th.thinner_done && expire)
                        wd_err <= 1'b1;
                end
                EVAL: begin
                    last_pixels <= pix_cnt;
                    pass_count  <= pass_count + 8'd1;
                    buf_sel     <= ~buf_sel;
                    prev_pix    <= pix_cnt;
                    converged   <= same && !abort;
                end
                FINISH: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thin_sequencer.sv
// Directed bench for thin_sequencer: convergence, pass limit, abort,
// coincident-pixel counting, async reset and watchdog expiry.
module tb_thin_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic        converged;
    logic [7:0]  pass_count;
    logic [18:0] last_pixels;
    logic        buf_sel;

    logic        wstart;
    logic        wabort;
    logic        wbusy;
    logic        wdone;
    logic        werror;
    logic        wconv;
    logic [7:0]  wpc;
    logic [18:0] wlp;
    logic        wbs;

    int total = 0;
    int bad   = 0;
    int ts_n  = 0;
    int dn_n  = 0;
    int wdn_n = 0;

    thin_sequencer_if tif ();
    thin_sequencer_if wif ();

    thin_sequencer #(
        .MAX_PASSES(4),
        .TIMEOUT(1000),
        .PIX_W(19)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .busy(busy),
        .done(done),
        .error(error),
        .converged(converged),
        .pass_count(pass_count),
        .last_pixels(last_pixels),
        .buf_sel(buf_sel),
        .th(tif.master)
    );

    thin_sequencer #(
        .MAX_PASSES(16),
        .TIMEOUT(100),
        .PIX_W(19)
    ) wdut (
        .clk(clk),
        .reset(reset),
        .start(wstart),
        .abort(wabort),
        .busy(wbusy),
        .done(wdone),
        .error(werror),
        .converged(wconv),
        .pass_count(wpc),
        .last_pixels(wlp),
        .buf_sel(wbs),
        .th(wif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tif.thinner_start) ts_n <= ts_n + 1;
        if (done)              dn_n <= dn_n + 1;
        if (wdone)             wdn_n <= wdn_n + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("st_busy", 32'(busy), 1);
        chk("st_ts", 32'(tif.thinner_start), 0);
        chk("st_conv", 32'(converged), 0);
        chk("st_bsel", 32'(buf_sel), 0);
    endtask

    // Model thinner: one non-counted write, one strobe-less data cycle,
    // then `ones` set-pixel writes with thinner_done on the last one.
    task automatic thin_pass(input int ones, input int pidx, input bit poke);
        bit seen = 1'b0;
        int waits = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            waits++;
            if (tif.thinner_start) seen = 1'b1;
        end
        chk("ts_seen", 32'(seen), 1);
        chk("ts_gap", waits, 1);
        tif.pix_we   = 1'b1;
        tif.pix_data = 1'b0;
        if (poke) start = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        tif.pix_we   = 1'b0;
        tif.pix_data = 1'b1;
        for (int i = 0; i < ones; i++) begin
            @(negedge clk);
            tif.pix_we       = 1'b1;
            tif.pix_data     = 1'b1;
            tif.thinner_done = (i == ones - 1);
        end
        @(negedge clk);
        tif.pix_we       = 1'b0;
        tif.pix_data     = 1'b0;
        tif.thinner_done = 1'b0;
        @(negedge clk);
        chk("last_px", 32'(last_pixels), ones);
        chk("pass_cnt", 32'(pass_count), pidx);
    endtask

    task automatic fin_chk(input int conv, input int pc, input int lp,
                           input int bs);
        chk("fin_pre", 32'(done), 0);
        @(negedge clk);
        chk("fin_done", 32'(done), 1);
        chk("fin_busy", 32'(busy), 0);
        chk("fin_err", 32'(error), 0);
        chk("fin_conv", 32'(converged), conv);
        chk("fin_pc", 32'(pass_count), pc);
        chk("fin_lp", 32'(last_pixels), lp);
        chk("fin_bsel", 32'(buf_sel), bs);
        @(negedge clk);
        chk("fin_pulse", 32'(done), 0);
    endtask

    task automatic wait_ts();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tif.thinner_start) seen = 1'b1;
        end
        chk("ts_wait", 32'(seen), 1);
    endtask

    initial begin
        int ts0;
        int dn0;
        int n;
        bit hit;
        reset            = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        wstart           = 1'b0;
        wabort           = 1'b0;
        tif.thinner_done = 1'b0;
        tif.pix_we       = 1'b0;
        tif.pix_data     = 1'b0;
        wif.thinner_done = 1'b0;
        wif.pix_we       = 1'b0;
        wif.pix_data     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_flags", 32'({busy, done, error, converged, buf_sel,
                              tif.thinner_start}), 0);
        chk("rst_pc", 32'(pass_count), 0);
        chk("rst_lp", 32'(last_pixels), 0);

        // converging run
        ts0 = ts_n;
        do_start();
        thin_pass(500, 1, 1'b0);
        thin_pass(420, 2, 1'b0);
        thin_pass(420, 3, 1'b0);
        fin_chk(1, 3, 420, 1);
        chk("conv_ts", ts_n - ts0, 3);
        repeat (2) @(negedge clk);
        chk("conv_hold", 32'(converged), 1);

        // pass limit of 4 with strictly decreasing counts
        ts0 = ts_n;
        do_start();
        thin_pass(400, 1, 1'b0);
        thin_pass(300, 2, 1'b0);
        thin_pass(200, 3, 1'b0);
        thin_pass(100, 4, 1'b0);
        fin_chk(0, 4, 100, 0);
        repeat (5) @(negedge clk);
        chk("lim_ts", ts_n - ts0, 4);

        // abort in the middle of pass 2
        ts0 = ts_n;
        do_start();
        thin_pass(300, 1, 1'b0);
        wait_ts();
        tif.pix_we   = 1'b1;
        tif.pix_data = 1'b1;
        repeat (10) @(negedge clk);
        tif.pix_we   = 1'b0;
        tif.pix_data = 1'b0;
        abort        = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_pre", 32'(done), 0);
        @(negedge clk);
        chk("ab_done", 32'(done), 1);
        chk("ab_err", 32'(error), 0);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_conv", 32'(converged), 0);
        chk("ab_pc", 32'(pass_count), 1);
        chk("ab_lp", 32'(last_pixels), 300);
        chk("ab_bsel", 32'(buf_sel), 1);
        repeat (5) @(negedge clk);
        chk("ab_ts", ts_n - ts0, 2);

        // coincident pixel counted, start during WAIT ignored
        ts0 = ts_n;
        do_start();
        thin_pass(7, 1, 1'b1);
        thin_pass(5, 2, 1'b0);
        thin_pass(5, 3, 1'b0);
        fin_chk(1, 3, 5, 1);
        repeat (3) @(negedge clk);
        chk("edge_ts", ts_n - ts0, 3);

        // async reset in WAIT of pass 2
        do_start();
        thin_pass(40, 1, 1'b0);
        wait_ts();
        tif.pix_we   = 1'b1;
        tif.pix_data = 1'b1;
        repeat (5) @(negedge clk);
        dn0 = dn_n;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_flags", 32'({busy, done, error, converged, buf_sel,
                             tif.thinner_start}), 0);
        chk("ar_pc", 32'(pass_count), 0);
        chk("ar_lp", 32'(last_pixels), 0);
        tif.pix_we   = 1'b0;
        tif.pix_data = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("ar_nodone", dn_n - dn0, 0);
        chk("ar_busy", 32'(busy), 0);
        do_start();
        thin_pass(60, 1, 1'b0);
        thin_pass(60, 2, 1'b0);
        fin_chk(1, 2, 60, 0);

        // watchdog: 100 WAIT cycles, then FINISH, then error pulse
        @(negedge clk);
        wstart = 1'b1;
        @(negedge clk);
        wstart = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (wif.thinner_start) hit = 1'b1;
        end
        chk("wd_ts", 32'(hit), 1);
        hit = 1'b0;
        n = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            n++;
            if (werror) hit = 1'b1;
        end
        chk("wd_seen", 32'(hit), 1);
        chk("wd_lat", n, 101);
        chk("wd_busy", 32'(wbusy), 0);
        chk("wd_nodone", wdn_n, 0);
        @(negedge clk);
        chk("wd_pulse", 32'(werror), 0);
        chk("wd_done2", 32'(wdone), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
